// File: rtl/hitbox_pkg.sv
// Shared types and constants for the hitbox scanner: box field layout,
// packed box type, FSM state encoding and an index-width helper.
package hitbox_pkg;

   localparam int COORD_W = 10;

   // Field position inside one packed box, in units of COORD_W.
   localparam int F_X1 = 0;
   localparam int F_X2 = 1;
   localparam int F_Y1 = 2;
   localparam int F_Y2 = 3;

   localparam int X1_OFS = F_X1 * COORD_W;
   localparam int X2_OFS = F_X2 * COORD_W;
   localparam int Y1_OFS = F_Y1 * COORD_W;
   localparam int Y2_OFS = F_Y2 * COORD_W;
   localparam int BOX_W  = 4 * COORD_W;

   typedef struct packed {
      logic [COORD_W-1:0] y2;
      logic [COORD_W-1:0] y1;
      logic [COORD_W-1:0] x2;
      logic [COORD_W-1:0] x1;
   } box_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_e;

   // A single-entry side still needs a 1-bit index register.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/hitbox_mux.sv
// Selects one packed box from a snapshot vector by index and unpacks it.
// Outputs are forced to zero while en_i is low.
module hitbox_mux #(
   parameter int N       = 4,
   parameter int COORD_W = hitbox_pkg::COORD_W,
   parameter int IDX_W   = hitbox_pkg::idx_width(N)
) (
   input  logic [N*4*COORD_W-1:0] boxes_i,
   input  logic [IDX_W-1:0]       idx_i,
   input  logic                   en_i,
   output logic [COORD_W-1:0]     x1_o,
   output logic [COORD_W-1:0]     x2_o,
   output logic [COORD_W-1:0]     y1_o,
   output logic [COORD_W-1:0]     y2_o
);
   import hitbox_pkg::*;

   // NOTE: every output gets a default before the loop, so no latch is inferred.
   always_comb begin
      x1_o = '0;
      x2_o = '0;
      y1_o = '0;
      y2_o = '0;
      for (int k = 0; k < N; k++) begin
         if (en_i && (idx_i == IDX_W'(k))) begin
            x1_o = boxes_i[k*4*COORD_W + F_X1*COORD_W +: COORD_W];
            x2_o = boxes_i[k*4*COORD_W + F_X2*COORD_W +: COORD_W];
            y1_o = boxes_i[k*4*COORD_W + F_Y1*COORD_W +: COORD_W];
            y2_o = boxes_i[k*4*COORD_W + F_Y2*COORD_W +: COORD_W];
         end
      end
   end

endmodule

// File: rtl/hitbox_scanner.sv
// Per-frame collision sequencer: snapshots both box sets on start, walks every
// A x B pair through the external detector, then publishes the hit matrix.
module hitbox_scanner #(
   parameter int NUM_A   = 4,
   parameter int NUM_B   = 4,
   parameter int COORD_W = hitbox_pkg::COORD_W
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic [NUM_A*4*COORD_W-1:0] a_boxes,
   input  logic [NUM_B*4*COORD_W-1:0] b_boxes,
   input  logic [NUM_A-1:0]           a_valid,
   input  logic [NUM_B-1:0]           b_valid,
   output logic [COORD_W-1:0]         det_a_x1,
   output logic [COORD_W-1:0]         det_a_x2,
   output logic [COORD_W-1:0]         det_a_y1,
   output logic [COORD_W-1:0]         det_a_y2,
   output logic [COORD_W-1:0]         det_b_x1,
   output logic [COORD_W-1:0]         det_b_x2,
   output logic [COORD_W-1:0]         det_b_y1,
   output logic [COORD_W-1:0]         det_b_y2,
   input  logic                       det_result,
   output logic                       busy,
   output logic                       done,
   output logic [NUM_A*NUM_B-1:0]     hit_matrix,
   output logic [NUM_A-1:0]           hit_a,
   output logic [NUM_B-1:0]           hit_b
);
   import hitbox_pkg::*;

   localparam int N  = NUM_A * NUM_B;
   localparam int AW = idx_width(NUM_A);
   localparam int BW = idx_width(NUM_B);

   state_e                     state_q, state_d;
   logic [AW-1:0]              i_q, i_d;
   logic [BW-1:0]              j_q, j_d;
   logic [NUM_A*4*COORD_W-1:0] a_snap_q, a_snap_d;
   logic [NUM_B*4*COORD_W-1:0] b_snap_q, b_snap_d;
   logic [NUM_A-1:0]           a_valid_q, a_valid_d;
   logic [NUM_B-1:0]           b_valid_q, b_valid_d;
   logic [N-1:0]               work_q, work_d;
   logic [N-1:0]               matrix_q, matrix_d;
   logic [NUM_A-1:0]           hit_a_q, hit_a_d;
   logic [NUM_B-1:0]           hit_b_q, hit_b_d;

   logic [N-1:0]     work_upd;
   logic [NUM_A-1:0] row_or;
   logic [NUM_B-1:0] col_or;
   logic             last_pair;
   logic             scanning;

   assign scanning  = (state_q == SCAN);
   assign last_pair = (i_q == AW'(NUM_A-1)) && (j_q == BW'(NUM_B-1));

   hitbox_mux #(.N(NUM_A), .COORD_W(COORD_W), .IDX_W(AW)) u_mux_a (
      .boxes_i (a_snap_q),
      .idx_i   (i_q),
      .en_i    (scanning),
      .x1_o    (det_a_x1),
      .x2_o    (det_a_x2),
      .y1_o    (det_a_y1),
      .y2_o    (det_a_y2)
   );

   hitbox_mux #(.N(NUM_B), .COORD_W(COORD_W), .IDX_W(BW)) u_mux_b (
      .boxes_i (b_snap_q),
      .idx_i   (j_q),
      .en_i    (scanning),
      .x1_o    (det_b_x1),
      .x2_o    (det_b_x2),
      .y1_o    (det_b_y1),
      .y2_o    (det_b_y2)
   );

   // Working matrix with the current pair's result merged in; publication on
   // the last pair uses this so the final bit is included.
   always_comb begin
      work_upd = work_q;
      for (int a = 0; a < NUM_A; a++) begin
         for (int b = 0; b < NUM_B; b++) begin
            if ((i_q == AW'(a)) && (j_q == BW'(b))) begin
               work_upd[a*NUM_B+b] = det_result & a_valid_q[a] & b_valid_q[b];
            end
         end
      end
   end

   always_comb begin
      row_or = '0;
      col_or = '0;
      for (int a = 0; a < NUM_A; a++) begin
         for (int b = 0; b < NUM_B; b++) begin
            row_or[a] = row_or[a] | work_upd[a*NUM_B+b];
            col_or[b] = col_or[b] | work_upd[a*NUM_B+b];
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      i_d       = i_q;
      j_d       = j_q;
      a_snap_d  = a_snap_q;
      b_snap_d  = b_snap_q;
      a_valid_d = a_valid_q;
      b_valid_d = b_valid_q;
      work_d    = work_q;
      matrix_d  = matrix_q;
      hit_a_d   = hit_a_q;
      hit_b_d   = hit_b_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = SCAN;
               a_snap_d  = a_boxes;
               b_snap_d  = b_boxes;
               a_valid_d = a_valid;
               b_valid_d = b_valid;
               i_d       = '0;
               j_d       = '0;
               work_d    = '0;
            end
         end
         SCAN: begin
            work_d = work_upd;
            if (last_pair) begin
               matrix_d = work_upd;
               hit_a_d  = row_or;
               hit_b_d  = col_or;
               i_d      = '0;
               j_d      = '0;
               state_d  = DONE;
            end else if (j_q == BW'(NUM_B-1)) begin
               j_d = '0;
               i_d = i_q + AW'(1);
            end else begin
               j_d = j_q + BW'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state updates use non-blocking assignments; the snapshot registers
   // are plain flops (not a RAM), so they are reset along with everything else.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         i_q       <= '0;
         j_q       <= '0;
         a_snap_q  <= '0;
         b_snap_q  <= '0;
         a_valid_q <= '0;
         b_valid_q <= '0;
         work_q    <= '0;
         matrix_q  <= '0;
         hit_a_q   <= '0;
         hit_b_q   <= '0;
      end else begin
         state_q   <= state_d;
         i_q       <= i_d;
         j_q       <= j_d;
         a_snap_q  <= a_snap_d;
         b_snap_q  <= b_snap_d;
         a_valid_q <= a_valid_d;
         b_valid_q <= b_valid_d;
         work_q    <= work_d;
         matrix_q  <= matrix_d;
         hit_a_q   <= hit_a_d;
         hit_b_q   <= hit_b_d;
      end
   end

   assign busy       = scanning;
   assign done       = (state_q == DONE);
   assign hit_matrix = matrix_q;
   assign hit_a      = hit_a_q;
   assign hit_b      = hit_b_q;

endmodule

// File: tb/tb_hitbox_scanner.sv
// Directed bench for hitbox_scanner (2x2 boxes) with an inclusive-overlap
// detector model wired to the det_* interface.
module tb_hitbox_scanner;
   import hitbox_pkg::*;

   localparam int NUM_A = 2;
   localparam int NUM_B = 2;
   localparam int CW    = 10;

   logic                    clk;
   logic                    rst_n;
   logic                    start;
   logic [NUM_A*4*CW-1:0]   a_boxes;
   logic [NUM_B*4*CW-1:0]   b_boxes;
   logic [NUM_A-1:0]        a_valid;
   logic [NUM_B-1:0]        b_valid;
   logic [CW-1:0]           det_a_x1, det_a_x2, det_a_y1, det_a_y2;
   logic [CW-1:0]           det_b_x1, det_b_x2, det_b_y1, det_b_y2;
   logic                    det_result;
   logic                    busy;
   logic                    done;
   logic [NUM_A*NUM_B-1:0]  hit_matrix;
   logic [NUM_A-1:0]        hit_a;
   logic [NUM_B-1:0]        hit_b;

   int n_tests = 0;
   int n_fail  = 0;

   hitbox_scanner #(.NUM_A(NUM_A), .NUM_B(NUM_B), .COORD_W(CW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .a_boxes    (a_boxes),
      .b_boxes    (b_boxes),
      .a_valid    (a_valid),
      .b_valid    (b_valid),
      .det_a_x1   (det_a_x1),
      .det_a_x2   (det_a_x2),
      .det_a_y1   (det_a_y1),
      .det_a_y2   (det_a_y2),
      .det_b_x1   (det_b_x1),
      .det_b_x2   (det_b_x2),
      .det_b_y1   (det_b_y1),
      .det_b_y2   (det_b_y2),
      .det_result (det_result),
      .busy       (busy),
      .done       (done),
      .hit_matrix (hit_matrix),
      .hit_a      (hit_a),
      .hit_b      (hit_b)
   );

   // External detector: inclusive rectangle overlap.
   assign det_result = (det_a_x1 <= det_b_x2) && (det_b_x1 <= det_a_x2) &&
                       (det_a_y1 <= det_b_y2) && (det_b_y1 <= det_a_y2);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic box_t mk(input int x1, input int x2, input int y1, input int y2);
      box_t b;
      b.x1 = CW'(x1);
      b.x2 = CW'(x2);
      b.y1 = CW'(y1);
      b.y2 = CW'(y2);
      return b;
   endfunction

   // Pulses start; reports the cycle (1 = cycle after the start edge) in which
   // done was first seen and the number of done cycles within a 12-cycle window.
   task automatic run_scan(output int dcyc, output int dcnt);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      dcyc = 0;
      dcnt = 0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (done) begin
            dcnt++;
            if (dcyc == 0) dcyc = c;
         end
      end
   endtask

   task automatic setup_first;
      a_boxes = {mk(500, 510, 500, 510), mk(10, 20, 10, 20)};
      b_boxes = {mk(15, 30, 15, 30), mk(300, 310, 100, 110)};
      a_valid = 2'b11;
      b_valid = 2'b11;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      start = 1'b0;
      setup_first();
      #23;
      n_tests++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_fail++; $display("FAIL reset_ctl: busy=%b done=%b expected 0 0", busy, done);
      end
      n_tests++;
      if (hit_matrix !== 4'b0000 || hit_a !== 2'b00 || hit_b !== 2'b00) begin
         n_fail++; $display("FAIL reset_hits: matrix=%b a=%b b=%b expected all 0", hit_matrix, hit_a, hit_b);
      end
      n_tests++;
      if ({det_a_x1, det_a_x2, det_a_y1, det_a_y2, det_b_x1, det_b_x2, det_b_y1, det_b_y2} !== '0) begin
         n_fail++; $display("FAIL reset_det: det outputs nonzero a_x1=%0d b_x1=%0d expected 0", det_a_x1, det_b_x1);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single_overlap;
      int dcyc, dcnt;
      setup_first();
      run_scan(dcyc, dcnt);
      n_tests++;
      if (hit_matrix !== 4'b0010) begin
         n_fail++; $display("FAIL single_matrix: got %b expected 0010", hit_matrix);
      end
      n_tests++;
      if (hit_a !== 2'b01 || hit_b !== 2'b10) begin
         n_fail++; $display("FAIL single_summary: hit_a=%b hit_b=%b expected 01 10", hit_a, hit_b);
      end
      n_tests++;
      if (dcyc !== 5 || dcnt !== 1) begin
         n_fail++; $display("FAIL single_done: cycle=%0d count=%0d expected 5 1", dcyc, dcnt);
      end
   endtask

   task automatic test_edge_touch;
      int dcyc, dcnt;
      a_boxes = {mk(500, 510, 500, 510), mk(40, 50, 10, 20)};
      b_boxes = {mk(200, 210, 200, 210), mk(50, 60, 15, 25)};
      a_valid = 2'b11;
      b_valid = 2'b11;
      run_scan(dcyc, dcnt);
      n_tests++;
      if (hit_matrix !== 4'b0001) begin
         n_fail++; $display("FAIL edge_touch: got %b expected 0001", hit_matrix);
      end
      b_boxes = {mk(200, 210, 200, 210), mk(51, 60, 15, 25)};
      run_scan(dcyc, dcnt);
      n_tests++;
      if (hit_matrix !== 4'b0000 || hit_a !== 2'b00 || hit_b !== 2'b00) begin
         n_fail++; $display("FAIL edge_gap: matrix=%b a=%b b=%b expected 0000 00 00", hit_matrix, hit_a, hit_b);
      end
   endtask

   task automatic test_valid_mask;
      int dcyc, dcnt;
      setup_first();
      run_scan(dcyc, dcnt);
      b_valid = 2'b01;
      run_scan(dcyc, dcnt);
      n_tests++;
      if (hit_matrix !== 4'b0000 || hit_a !== 2'b00 || hit_b !== 2'b00) begin
         n_fail++; $display("FAIL mask_matrix: matrix=%b a=%b b=%b expected 0000 00 00", hit_matrix, hit_a, hit_b);
      end
      n_tests++;
      if (dcyc !== 5) begin
         n_fail++; $display("FAIL mask_done: cycle=%0d expected 5", dcyc);
      end
   endtask

   task automatic test_snapshot;
      int dcyc, dcnt;
      setup_first();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      dcyc = 0;
      dcnt = 0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (c == 1) b_boxes = {mk(700, 710, 700, 710), mk(300, 310, 100, 110)};
         if (c == 2) start = 1'b1;
         if (done) begin
            dcnt++;
            if (dcyc == 0) dcyc = c;
         end
      end
      n_tests++;
      if (hit_matrix !== 4'b0010 || hit_a !== 2'b01 || hit_b !== 2'b10) begin
         n_fail++; $display("FAIL snapshot_hits: matrix=%b a=%b b=%b expected 0010 01 10", hit_matrix, hit_a, hit_b);
      end
      n_tests++;
      if (dcyc !== 5 || dcnt !== 1) begin
         n_fail++; $display("FAIL snapshot_done: cycle=%0d count=%0d expected 5 1", dcyc, dcnt);
      end
   endtask

   task automatic test_reset_mid_scan;
      int dcnt;
      setup_first();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      n_tests++;
      if (busy !== 1'b1 || det_a_x1 !== 10'd10 || det_b_x1 !== 10'd300) begin
         n_fail++; $display("FAIL pair0_det: busy=%b a_x1=%0d b_x1=%0d expected 1 10 300", busy, det_a_x1, det_b_x1);
      end
      @(negedge clk);
      n_tests++;
      if (det_a_x2 !== 10'd20 || det_b_x1 !== 10'd15 || det_b_y2 !== 10'd30) begin
         n_fail++; $display("FAIL pair1_det: a_x2=%0d b_x1=%0d b_y2=%0d expected 20 15 30", det_a_x2, det_b_x1, det_b_y2);
      end
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (busy !== 1'b0 || done !== 1'b0 || hit_matrix !== 4'b0000 || hit_a !== 2'b00 || hit_b !== 2'b00) begin
         n_fail++; $display("FAIL midrst_outputs: busy=%b done=%b matrix=%b a=%b b=%b expected all 0",
                            busy, done, hit_matrix, hit_a, hit_b);
      end
      n_tests++;
      if ({det_a_x1, det_a_x2, det_a_y1, det_a_y2, det_b_x1, det_b_x2, det_b_y1, det_b_y2} !== '0) begin
         n_fail++; $display("FAIL midrst_det: a_x1=%0d b_x1=%0d expected 0", det_a_x1, det_b_x1);
      end
      @(negedge clk);
      rst_n = 1'b1;
      dcnt = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (done) dcnt++;
      end
      n_tests++;
      if (dcnt !== 0 || hit_matrix !== 4'b0000 || busy !== 1'b0) begin
         n_fail++; $display("FAIL midrst_after: done_count=%0d matrix=%b busy=%b expected 0 0000 0", dcnt, hit_matrix, busy);
      end
   endtask

   initial begin
      test_reset();
      test_single_overlap();
      test_edge_touch();
      test_valid_mask();
      test_snapshot();
      test_reset_mid_scan();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
